game_sequencer: RTL and testbench

Central game controller for the breakout datapath. It runs the game-phase state machine (idle, serve, play, win, lose) and derives a per-frame tick from vsync. It round-robin arbitrates block-hit reports from three balls into the shared block_to_del register consumed by display_logic, and tracks remaining blocks and lives to produce the win/lose flags.

---
 rtl/game_sequencer.sv | 164 ++++++++++++++++
 tb/tb_game_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - breakout game-phase FSM, frame tick, round-robin block-hit arbiter
module game_sequencer #(
   parameter int NUM_BLOCKS   = 13,
   parameter int LIVES        = 3,
   parameter int SERVE_FRAMES = 60
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  vsync,
   input  logic [2:0]            hit_req,
   input  logic [11:0]           hit_idx,
   input  logic                  ball_lost,
   output logic [2:0]            hit_ack,
   output logic [NUM_BLOCKS-1:0] block_to_del,
   output logic [3:0]            blocks_left,
   output logic [1:0]            lives,
   output logic                  serve,
   output logic                  ball_en,
   output logic                  win,
   output logic                  lose,
   output logic                  frame_tick
);

   localparam logic [3:0] NB4   = 4'(NUM_BLOCKS);
   localparam logic [1:0] LIV2  = 2'(LIVES);
   localparam logic [7:0] SERV8 = 8'(SERVE_FRAMES);

   typedef enum logic [2:0] {S_IDLE, S_SERVE, S_PLAY, S_WIN, S_LOSE} state_t;

   state_t                  state, state_nxt;
   logic [NUM_BLOCKS-1:0]   blk_nxt;
   logic [3:0]              bl_nxt;
   logic [1:0]              lives_nxt;
   logic [2:0]              ack_nxt;
   logic [1:0]              rr, rr_nxt;
   logic [7:0]              cnt, cnt_nxt;
   logic                    vsync_d, start_d;
   logic                    start_rise;
   logic [2:0]              elig;
   logic [2:0]              p;
   logic                    gv;
   logic [1:0]              gk;
   logic [3:0]              sel_idx;
   logic                    new_hit;

   assign start_rise = start & ~start_d;
   // A requester whose ack is high this cycle is skipped so it can drop its request.
   assign elig       = hit_req & ~hit_ack;

   always_comb begin
      gv = 1'b0;
      gk = 2'd0;
      p  = 3'd0;
      for (int i = 0; i < 3; i++) begin
         p = {1'b0, rr} + 3'(i);
         if (p >= 3'd3) p = p - 3'd3;
         if (!gv && elig[p[1:0]]) begin
            gv = 1'b1;
            gk = p[1:0];
         end
      end
   end

   always_comb begin
      case (gk)
         2'd1:    sel_idx = hit_idx[7:4];
         2'd2:    sel_idx = hit_idx[11:8];
         default: sel_idx = hit_idx[3:0];
      endcase
   end

   assign new_hit = gv && (sel_idx < NB4) && !block_to_del[sel_idx];

   always_comb begin
      state_nxt = state;
      blk_nxt   = block_to_del;
      bl_nxt    = blocks_left;
      lives_nxt = lives;
      ack_nxt   = 3'b000;
      rr_nxt    = rr;
      cnt_nxt   = cnt;
      case (state)
         S_IDLE: begin
            if (start_rise) begin
               state_nxt = S_SERVE;
               cnt_nxt   = 8'd0;
            end
         end
         S_SERVE: begin
            if (cnt == SERV8) state_nxt = S_PLAY;
            else if (frame_tick) cnt_nxt = cnt + 8'd1;
         end
         S_PLAY: begin
            if (gv) begin
               ack_nxt[gk] = 1'b1;
               rr_nxt      = (gk == 2'd2) ? 2'd0 : gk + 2'd1;
               if (new_hit && blocks_left != 4'd0) begin
                  blk_nxt[sel_idx] = 1'b1;
                  bl_nxt           = blocks_left - 4'd1;
               end
            end
            // Clearing the last block takes priority over a simultaneous lost ball.
            if (new_hit && blocks_left == 4'd1) begin
               state_nxt = S_WIN;
            end else if (ball_lost) begin
               if (lives <= 2'd1) begin
                  lives_nxt = 2'd0;
                  state_nxt = S_LOSE;
               end else begin
                  lives_nxt = lives - 2'd1;
                  state_nxt = S_SERVE;
                  cnt_nxt   = 8'd0;
               end
            end
         end
         S_WIN, S_LOSE: begin
            if (start_rise) begin
               blk_nxt   = '0;
               bl_nxt    = NB4;
               lives_nxt = LIV2;
               state_nxt = S_SERVE;
               cnt_nxt   = 8'd0;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         block_to_del <= '0;
         blocks_left  <= NB4;
         lives        <= LIV2;
         hit_ack      <= 3'b000;
         rr           <= 2'd0;
         cnt          <= 8'd0;
         vsync_d      <= 1'b1;
         start_d      <= 1'b0;
         frame_tick   <= 1'b0;
         serve        <= 1'b0;
         ball_en      <= 1'b0;
         win          <= 1'b0;
         lose         <= 1'b0;
      end else begin
         state        <= state_nxt;
         block_to_del <= blk_nxt;
         blocks_left  <= bl_nxt;
         lives        <= lives_nxt;
         hit_ack      <= ack_nxt;
         rr           <= rr_nxt;
         cnt          <= cnt_nxt;
         vsync_d      <= vsync;
         start_d      <= start;
         frame_tick   <= vsync_d & ~vsync;
         serve        <= (state_nxt == S_SERVE);
         ball_en      <= (state_nxt == S_PLAY);
         win          <= (state_nxt == S_WIN);
         lose         <= (state_nxt == S_LOSE);
      end
   end

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - directed self-checking bench for game_sequencer
module tb_game_sequencer;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic        vsync;
   logic [2:0]  hit_req;
   logic [11:0] hit_idx;
   logic        ball_lost;
   logic [2:0]  hit_ack;
   logic [12:0] block_to_del;
   logic [3:0]  blocks_left;
   logic [1:0]  lives;
   logic        serve;
   logic        ball_en;
   logic        win;
   logic        lose;
   logic        frame_tick;

   int checks;
   int failures;

   game_sequencer dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .vsync        (vsync),
      .hit_req      (hit_req),
      .hit_idx      (hit_idx),
      .ball_lost    (ball_lost),
      .hit_ack      (hit_ack),
      .block_to_del (block_to_del),
      .blocks_left  (blocks_left),
      .lives        (lives),
      .serve        (serve),
      .ball_en      (ball_en),
      .win          (win),
      .lose         (lose),
      .frame_tick   (frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      vsync = 1'b1;
      forever begin
         repeat (100) @(posedge clk);
         #2 vsync = ~vsync;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_play();
      int ticks;
      ticks = 0;
      for (int n = 0; n < 13000; n++) begin
         if (serve && frame_tick) ticks++;
         if (ball_en) break;
         step();
      end
      chk("play_ball_en", ball_en, 1);
      chk("play_serve", serve, 0);
      chk("serve_ticks", ticks, 60);
   endtask

   task automatic do_hit(input int k, input logic [3:0] idx,
                         input logic [12:0] exp_blk, input logic [3:0] exp_bl);
      hit_idx[4*k +: 4] = idx;
      hit_req[k] = 1'b1;
      for (int n = 0; n < 6; n++) begin
         step();
         if (hit_ack != 3'b000) break;
      end
      chk("hit_ack", hit_ack, 32'(1) << k);
      chk("hit_blk", block_to_del, exp_blk);
      chk("hit_left", blocks_left, exp_bl);
      hit_req[k] = 1'b0;
      step();
   endtask

   initial begin
      logic [12:0] exp_blk;
      int          acks_seen;
      checks    = 0;
      failures  = 0;
      reset_n   = 1'b0;
      start     = 1'b0;
      hit_req   = 3'b000;
      hit_idx   = 12'h000;
      ball_lost = 1'b0;
      repeat (3) step();

      chk("rst_left", blocks_left, 13);
      chk("rst_lives", lives, 3);
      chk("rst_blk", block_to_del, 0);
      chk("rst_flags", {serve, ball_en, win, lose, frame_tick, hit_ack}, 0);
      reset_n = 1'b1;
      step();

      // Test 1: frame tick and serve/play transition
      for (int n = 0; n < 300 && !vsync; n++) step();
      for (int n = 0; n < 300 && vsync; n++) step();
      chk("tick_on_fall", frame_tick, 1);
      step();
      chk("tick_one_cycle", frame_tick, 0);
      pulse_start();
      chk("serve_on_start", serve, 1);
      wait_play();

      // Test 2: round robin over three simultaneous requests
      hit_idx = {4'd2, 4'd1, 4'd0};
      hit_req = 3'b111;
      step();
      chk("rr_ack0", hit_ack, 3'b001);
      hit_req = 3'b110;
      step();
      chk("rr_ack1", hit_ack, 3'b010);
      hit_req = 3'b100;
      step();
      chk("rr_ack2", hit_ack, 3'b100);
      hit_req = 3'b000;
      step();
      chk("rr_ack_idle", hit_ack, 0);
      chk("rr_blk", block_to_del, 13'h0007);
      chk("rr_left", blocks_left, 10);

      // Test 3: double hit and out-of-range index
      do_hit(0, 4'd5, 13'h0027, 4'd9);
      do_hit(0, 4'd5, 13'h0027, 4'd9);
      do_hit(0, 4'd14, 13'h0027, 4'd9);

      // Test 4: losing all lives
      ball_lost = 1'b1; step(); ball_lost = 1'b0;
      chk("lost1_lives", lives, 2);
      chk("lost1_serve", serve, 1);
      wait_play();
      ball_lost = 1'b1; step(); ball_lost = 1'b0;
      chk("lost2_lives", lives, 1);
      chk("lost2_serve", serve, 1);
      wait_play();
      ball_lost = 1'b1; step(); ball_lost = 1'b0;
      chk("lost3_lives", lives, 0);
      chk("lost3_lose", lose, 1);
      chk("lost3_serve", serve, 0);
      ball_lost = 1'b1; step(); ball_lost = 1'b0;
      chk("lose_lives_sat", lives, 0);
      hit_idx[3:0] = 4'd14;
      hit_req = 3'b001;
      acks_seen = 0;
      for (int n = 0; n < 8; n++) begin
         step();
         if (hit_ack != 3'b000) acks_seen++;
      end
      chk("lose_no_ack", acks_seen, 0);
      chk("lose_left", blocks_left, 9);

      pulse_start();
      chk("restart_serve", serve, 1);
      chk("restart_lives", lives, 3);
      chk("restart_left", blocks_left, 13);
      chk("restart_blk", block_to_del, 0);
      wait_play();
      step();
      chk("pending_ack", hit_ack, 3'b001);
      hit_req = 3'b000;
      step();
      chk("pending_left", blocks_left, 13);

      // Test 5: last block and ball_lost together
      exp_blk = 13'h0000;
      for (int i = 0; i < 12; i++) begin
         exp_blk[i] = 1'b1;
         do_hit(0, 4'(i), exp_blk, 4'(12 - i));
      end
      hit_idx[7:4] = 4'd12;
      hit_req = 3'b010;
      ball_lost = 1'b1;
      step();
      ball_lost = 1'b0;
      hit_req = 3'b000;
      chk("win_flag", win, 1);
      chk("win_ack", hit_ack, 3'b010);
      chk("win_lives", lives, 3);
      chk("win_left", blocks_left, 0);
      chk("win_blk", block_to_del, 13'h1FFF);
      step();
      chk("win_hold", {win, ball_en, serve}, 3'b100);

      // Test 6: restart from WIN, then asynchronous reset mid-play
      pulse_start();
      chk("win_restart_serve", serve, 1);
      chk("win_restart_blk", block_to_del, 0);
      chk("win_restart_left", blocks_left, 13);
      wait_play();
      do_hit(2, 4'd3, 13'h0008, 4'd12);
      do_hit(1, 4'd4, 13'h0018, 4'd11);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_blk", block_to_del, 0);
      chk("async_left", blocks_left, 13);
      chk("async_lives", lives, 3);
      chk("async_flags", {serve, ball_en, win, lose, hit_ack}, 0);
      step();
      reset_n = 1'b1;
      step();
      chk("post_rst_idle", {serve, ball_en}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
